// File: rtl/fma16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fma16_pkg
//  Description : Shared types for the fma16 issue stage: operation and
//                rounding-mode encodings, the queued request record and the
//                op -> {mul,add,negr,negz} decode function.
//  Revision    : 1.0 - initial release
// ============================================================================
package fma16_pkg;

    typedef enum logic [2:0] {
        OP_FADD   = 3'd0,
        OP_FSUB   = 3'd1,
        OP_FMUL   = 3'd2,
        OP_FMADD  = 3'd3,
        OP_FMSUB  = 3'd4,
        OP_FNMADD = 3'd5,
        OP_FNMSUB = 3'd6,
        OP_RSVD   = 3'd7
    } fma16_op_e;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RP  = 2'b10,
        RM_RN  = 2'b11
    } fma16_rm_e;

    // ctrl is {mul, add, negr, negz}
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        fma16_rm_e   rm;
    } fma16_req_t;

    // Reserved op decodes to all-zero controls, which makes fma16 pass x.
    function automatic logic [3:0] decode_op(input fma16_op_e op);
        logic [3:0] ctrl;
        case (op)
            OP_FADD:   ctrl = 4'b0100;
            OP_FSUB:   ctrl = 4'b0101;
            OP_FMUL:   ctrl = 4'b1000;
            OP_FMADD:  ctrl = 4'b1100;
            OP_FMSUB:  ctrl = 4'b1101;
            OP_FNMADD: ctrl = 4'b1110;
            OP_FNMSUB: ctrl = 4'b1111;
            default:   ctrl = 4'b0000;
        endcase
        return ctrl;
    endfunction

endpackage : fma16_pkg
`default_nettype wire

// File: rtl/fma16_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fma16_op_decode
//  Description : Combinational op decoder used on the queue push path.
//                Produces {mul, add, negr, negz} for an incoming op code.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma16_op_decode
    import fma16_pkg::*;
(
    input  logic [2:0] op,
    output logic [3:0] ctrl
);

    assign ctrl = decode_op(fma16_op_e'(op));

endmodule : fma16_op_decode
`default_nettype wire

// File: rtl/fma16_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fma16_issue_queue
//  Description : In-order operand/issue queue in front of fma16. Requests are
//                decoded at push and stored in a DEPTH-entry register array;
//                the head entry drives fma16 over a valid/ready handshake.
//                Optional feature macro: FMA16_IQ_ILLEGAL_OP_EN - adds the
//                err_illegal port; op 7 is then consumed but not enqueued.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma16_issue_queue
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [15:0]              in_x,
    input  logic [15:0]              in_y,
    input  logic [15:0]              in_z,
    input  logic [1:0]               in_roundmode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              x,
    output logic [15:0]              y,
    output logic [15:0]              z,
    output logic                     mul,
    output logic                     add,
    output logic                     negr,
    output logic                     negz,
    output logic [1:0]               roundmode,
`ifdef FMA16_IQ_ILLEGAL_OP_EN
    output logic                     err_illegal,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_rst_done;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_enq;
    logic [3:0]         w_in_ctrl;
    fma16_req_t         w_in_req;
    fma16_req_t         w_mem [DEPTH];
    fma16_req_t         w_head;
    logic [c_ptr_w-1:0] w_rd_idx;

    // ------------------------------------------------------------------
    // Handshake and occupancy flags
    // ------------------------------------------------------------------
    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = r_rst_done & ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

`ifdef FMA16_IQ_ILLEGAL_OP_EN
    logic w_illegal;
    logic r_err_illegal;

    // Reserved op completes the handshake but is never stored
    assign w_illegal   = (in_op == 3'(OP_RSVD));
    assign w_enq       = w_push & ~w_illegal;
    assign err_illegal = r_err_illegal;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_illegal <= 1'b0;
        end else if (w_push && w_illegal) begin
            r_err_illegal <= 1'b1;
        end
    end
`else
    assign w_enq = w_push;
`endif

    // ------------------------------------------------------------------
    // Push-path decode and request packing
    // ------------------------------------------------------------------
    fma16_op_decode u_op_decode (
        .op   (in_op),
        .ctrl (w_in_ctrl)
    );

    assign w_in_req.ctrl = w_in_ctrl;
    assign w_in_req.x    = in_x;
    assign w_in_req.y    = in_y;
    assign w_in_req.z    = in_z;
    assign w_in_req.rm   = fma16_rm_e'(in_roundmode);

    // ------------------------------------------------------------------
    // Storage: one register per slot, written when it is the write target
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        fma16_req_t r_entry;

        // Capture the incoming request into this slot
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_entry <= '0;
            end else if (w_enq && (r_wr_ptr == c_ptr_w'(gi))) begin
                r_entry <= w_in_req;
            end
        end

        assign w_mem[gi] = r_entry;
    end

    // ------------------------------------------------------------------
    // Head selection. When empty, the read pointer has already moved past
    // the last popped slot, so look one slot back to keep its data on the
    // outputs. That slot cannot be overwritten while the queue is empty.
    // ------------------------------------------------------------------
    assign w_rd_idx = w_empty ? (r_rd_ptr - c_ptr_w'(1)) : r_rd_ptr;
    assign w_head   = w_mem[w_rd_idx];

    assign x                       = w_head.x;
    assign y                       = w_head.y;
    assign z                       = w_head.z;
    assign {mul, add, negr, negz}  = w_head.ctrl;
    assign roundmode               = w_head.rm;

    // ------------------------------------------------------------------
    // Occupancy next-state
    // ------------------------------------------------------------------
    // Count moves only when exactly one of enqueue/dequeue happens
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and reset-release tracking registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_count    <= w_count_nxt;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

endmodule : fma16_issue_queue
`default_nettype wire
